// File: rtl/ghost_move_scheduler_pkg.sv
// rtl/ghost_move_scheduler_pkg.sv - shared types, board constants and tile helpers for the ghost scheduler
package ghost_move_scheduler_pkg;

  localparam int NUM_GHOSTS    = 4;
  localparam int POS_W_DEF     = 10;
  localparam int SCATTER_TICKS = 7;
  localparam int CHASE_TICKS   = 20;
  localparam int FRIGHT_TICKS  = 6;
  localparam int TIMEOUT       = 15;

  typedef enum logic [1:0] {SCATTER = 2'b00, CHASE = 2'b01, FRIGHT = 2'b10} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COMMIT} sched_state_e;

  function automatic logic [POS_W_DEF-1:0] to_pos(input int unsigned x, input int unsigned y);
    return POS_W_DEF'(y * 32 + x);
  endfunction

  // Packed arrays, element i belongs to ghost i (blinky, pinky, inky, clyde).
  localparam logic [NUM_GHOSTS-1:0][POS_W_DEF-1:0] GHOST_HOME =
    {to_pos(16, 14), to_pos(12, 14), to_pos(14, 14), to_pos(13, 11)};
  localparam logic [NUM_GHOSTS-1:0][POS_W_DEF-1:0] SCATTER_CORNER =
    {to_pos(0, 31), to_pos(27, 31), to_pos(2, 0), to_pos(25, 0)};

endpackage

// File: rtl/ghost_move_scheduler_if.sv
// rtl/ghost_move_scheduler_if.sv - request/ack link to the shared next-location unit
interface ghost_move_scheduler_if #(
  parameter int POS_W = 10
) ();
  logic             nl_req;
  logic [POS_W-1:0] nl_curr_pos;
  logic [POS_W-1:0] nl_target_pos;
  logic             nl_ack;
  logic [POS_W-1:0] nl_next_pos;

  modport master (output nl_req, nl_curr_pos, nl_target_pos, input nl_ack, nl_next_pos);
  modport slave  (input nl_req, nl_curr_pos, nl_target_pos, output nl_ack, nl_next_pos);
endinterface

// File: rtl/ghost_move_scheduler_mode_timer.sv
// rtl/ghost_move_scheduler_mode_timer.sv - scatter/chase phase timer with frightened override
module ghost_move_scheduler_mode_timer
  import ghost_move_scheduler_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  adv_i,
  input  logic  pellet_i,
  input  logic  restart_i,
  output mode_e mode_o,
  output mode_e mode_next_o
);
  localparam int PH_W = $clog2(CHASE_TICKS + 1);
  localparam int FR_W = $clog2(FRIGHT_TICKS + 1);

  mode_e           base_q, base_d;
  logic [PH_W-1:0] ph_cnt_q, ph_cnt_d, ph_limit;
  logic            fright_q, fright_d;
  logic [FR_W-1:0] fr_cnt_q, fr_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= SCATTER;
      ph_cnt_q <= '0;
      fright_q <= 1'b0;
      fr_cnt_q <= '0;
    end else begin
      base_q   <= base_d;
      ph_cnt_q <= ph_cnt_d;
      fright_q <= fright_d;
      fr_cnt_q <= fr_cnt_d;
    end
  end

  // Pellet lands before a same-cycle tick; the base count stays frozen while frightened.
  always_comb begin
    base_d   = base_q;
    ph_cnt_d = ph_cnt_q;
    fright_d = fright_q;
    fr_cnt_d = fr_cnt_q;
    ph_limit = (base_q == SCATTER) ? PH_W'(SCATTER_TICKS) : PH_W'(CHASE_TICKS);
    if (restart_i) begin
      base_d   = SCATTER;
      ph_cnt_d = '0;
      fright_d = 1'b0;
      fr_cnt_d = '0;
    end else begin
      if (pellet_i) begin
        fright_d = 1'b1;
        fr_cnt_d = '0;
      end
      if (adv_i) begin
        if (fright_d) begin
          if (fr_cnt_d >= FR_W'(FRIGHT_TICKS - 1)) begin
            fright_d = 1'b0;
            fr_cnt_d = '0;
          end else begin
            fr_cnt_d = fr_cnt_d + 1'b1;
          end
        end else if (ph_cnt_q >= ph_limit - 1'b1) begin
          base_d   = (base_q == SCATTER) ? CHASE : SCATTER;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
    end
  end

  assign mode_o      = fright_q ? FRIGHT : base_q;
  assign mode_next_o = fright_d ? FRIGHT : base_d;
endmodule

// File: rtl/ghost_move_scheduler.sv
// rtl/ghost_move_scheduler.sv - per-tick ghost sequencer over the shared next-location unit
// Optional: GHOST_TIMEOUT_EN adds an nl_ack timeout and a sticky timeout_err_o pin.
module ghost_move_scheduler
  import ghost_move_scheduler_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tick_i,
  input  logic                            restart_i,
  input  logic                            pellet_i,
  input  logic [NUM_GHOSTS*POS_W_DEF-1:0] ghost_target_i,
  ghost_move_scheduler_if.master          nl,
  output logic [NUM_GHOSTS*POS_W_DEF-1:0] ghost_pos_o,
  output logic [NUM_GHOSTS-1:0]           ghost_moved_o,
  output logic [1:0]                      mode_o,
  output logic                            busy_o,
  output logic                            overrun_o
`ifdef GHOST_TIMEOUT_EN
  ,
  output logic                            timeout_err_o
`endif
);
  localparam int IDX_W = $clog2(NUM_GHOSTS);

  sched_state_e                          state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [POS_W_DEF-1:0]                  curr_q, curr_d, tgt_q, tgt_d;
  logic [NUM_GHOSTS-1:0][POS_W_DEF-1:0]  pos_q, pos_d;
  logic [NUM_GHOSTS-1:0]                 moved_q, moved_d;
  logic                                  overrun_q, overrun_d;
  mode_e                                 mode_cur, mode_next;
`ifdef GHOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]                       to_cnt_q, to_cnt_d;
  logic                                  terr_q, terr_d;
`endif

  // Fright redirect (idx+2) mod NUM_GHOSTS relies on the index wrapping, so NUM_GHOSTS is a power of two.
  function automatic logic [POS_W_DEF-1:0] pick_target(input mode_e m, input logic [IDX_W-1:0] i,
                                                       input logic [NUM_GHOSTS*POS_W_DEF-1:0] chase);
    case (m)
      SCATTER: pick_target = SCATTER_CORNER[i];
      CHASE:   pick_target = chase[i*POS_W_DEF +: POS_W_DEF];
      default: pick_target = SCATTER_CORNER[i + IDX_W'(2)];
    endcase
  endfunction

  ghost_move_scheduler_mode_timer u_mode_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (tick_i && (state_q == S_IDLE)),
    .pellet_i   (pellet_i),
    .restart_i  (restart_i),
    .mode_o     (mode_cur),
    .mode_next_o(mode_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      curr_q    <= '0;
      tgt_q     <= '0;
      pos_q     <= GHOST_HOME;
      moved_q   <= '0;
      overrun_q <= 1'b0;
`ifdef GHOST_TIMEOUT_EN
      to_cnt_q  <= '0;
      terr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      curr_q    <= curr_d;
      tgt_q     <= tgt_d;
      pos_q     <= pos_d;
      moved_q   <= moved_d;
      overrun_q <= overrun_d;
`ifdef GHOST_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      terr_q    <= terr_d;
`endif
    end
  end

  // Operands are captured on every entry to REQ using the mode in force after that edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    curr_d    = curr_q;
    tgt_d     = tgt_q;
    pos_d     = pos_q;
    moved_d   = '0;
    overrun_d = overrun_q || (tick_i && (state_q != S_IDLE));
`ifdef GHOST_TIMEOUT_EN
    to_cnt_d  = '0;
    terr_d    = terr_q;
`endif
    if (restart_i) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      curr_d    = '0;
      tgt_d     = '0;
      pos_d     = GHOST_HOME;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (tick_i) begin
          state_d = S_REQ;
          idx_d   = '0;
          curr_d  = pos_q[0];
          tgt_d   = pick_target(mode_next, '0, ghost_target_i);
        end
        S_REQ: if (nl.nl_ack) begin
          pos_d[idx_q]   = nl.nl_next_pos;
          moved_d[idx_q] = 1'b1;
          state_d        = S_COMMIT;
        end
`ifdef GHOST_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_COMMIT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
        S_COMMIT: if (idx_q == IDX_W'(NUM_GHOSTS - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          state_d = S_REQ;
          idx_d   = idx_q + 1'b1;
          curr_d  = pos_q[idx_q + 1'b1];
          tgt_d   = pick_target(mode_next, idx_q + 1'b1, ghost_target_i);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    nl.nl_req = (state_q == S_REQ);
    busy_o    = (state_q != S_IDLE);
  end

  assign nl.nl_curr_pos   = curr_q;
  assign nl.nl_target_pos = tgt_q;
  assign ghost_pos_o      = pos_q;
  assign ghost_moved_o    = moved_q;
  assign mode_o           = mode_cur;
  assign overrun_o        = overrun_q;
`ifdef GHOST_TIMEOUT_EN
  assign timeout_err_o    = terr_q;
`endif
endmodule

// File: tb/tb_ghost_move_scheduler.sv
// tb/tb_ghost_move_scheduler.sv - randomized self-checking bench for ghost_move_scheduler
module tb_ghost_move_scheduler;
  import ghost_move_scheduler_pkg::*;
  localparam int PW = POS_W_DEF;

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, restart = 1'b0, pellet = 1'b0;
  logic [NUM_GHOSTS*PW-1:0] gtgt = '0;
  logic [NUM_GHOSTS*PW-1:0] gpos;
  logic [NUM_GHOSTS-1:0]    gmoved;
  logic [1:0]               mode;
  logic                     busy, overrun;
`ifdef GHOST_TIMEOUT_EN
  logic                     terr;
`endif

  ghost_move_scheduler_if #(.POS_W(PW)) nl_if ();

  ghost_move_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick),
    .restart_i     (restart),
    .pellet_i      (pellet),
    .ghost_target_i(gtgt),
    .nl            (nl_if),
    .ghost_pos_o   (gpos),
    .ghost_moved_o (gmoved),
    .mode_o        (mode),
    .busy_o        (busy),
    .overrun_o     (overrun)
`ifdef GHOST_TIMEOUT_EN
    ,
    .timeout_err_o (terr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: countdowns of ticks left in the current phase.
  int m_base, m_left, m_fright, m_fleft, mpos[NUM_GHOSTS];
  bit m_over;

  function automatic int m_mode();
    return (m_fright != 0) ? 2 : m_base;
  endfunction

  task automatic m_restart();
    m_base = 0; m_left = SCATTER_TICKS; m_fright = 0; m_fleft = 0; m_over = 0;
    for (int i = 0; i < NUM_GHOSTS; i++) mpos[i] = int'(GHOST_HOME[i]);
  endtask

  task automatic m_pellet();
    m_fright = 1; m_fleft = FRIGHT_TICKS;
  endtask

  task automatic m_tick();
    if (m_fright != 0) begin
      m_fleft--;
      if (m_fleft == 0) m_fright = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_base = 1 - m_base;
        m_left = (m_base == 1) ? CHASE_TICKS : SCATTER_TICKS;
      end
    end
  endtask

  function automatic int exp_target(int g);
    case (m_mode())
      0:       return int'(SCATTER_CORNER[g]);
      1:       return int'(gtgt[g*PW +: PW]);
      default: return int'(SCATTER_CORNER[(g + 2) % NUM_GHOSTS]);
    endcase
  endfunction

  int ack_dly[NUM_GHOSTS], np_force[NUM_GHOSTS], pellet_at, tick_mid_at;
  bit pellet_w_tick;

  task automatic set_defaults();
    for (int i = 0; i < NUM_GHOSTS; i++) begin ack_dly[i] = 0; np_force[i] = -1; end
    pellet_at = -1; tick_mid_at = -1; pellet_w_tick = 0;
  endtask

  task automatic check_all_pos(input string tag);
    for (int i = 0; i < NUM_GHOSTS; i++) chk(tag, gpos[i*PW +: PW], mpos[i]);
  endtask

  // Runs one full round starting from IDLE; ack_dly < 0 means no ack at all.
  task automatic run_round();
    int nd, etg, ecur, last;
    tick = 1'b1;
    if (pellet_w_tick) begin pellet = 1'b1; m_pellet(); end
    m_tick();
    @(posedge clk); #1;
    tick = 1'b0; pellet = 1'b0;
    for (int g = 0; g < NUM_GHOSTS; g++) begin
      etg  = exp_target(g);
      ecur = mpos[g];
      nd   = (np_force[g] >= 0) ? np_force[g] : int'($urandom_range(0, 1023));
      last = (ack_dly[g] < 0) ? TIMEOUT - 1 : ack_dly[g];
      for (int d = 0; d <= last; d++) begin
        chk("nl_req", nl_if.nl_req, 1);
        chk("nl_curr_pos", nl_if.nl_curr_pos, ecur);
        chk("nl_target_pos", nl_if.nl_target_pos, etg);
        nl_if.nl_ack      = (d == last) && (ack_dly[g] >= 0);
        nl_if.nl_next_pos = (d == last) ? PW'(nd) : PW'($urandom_range(0, 1023));
        @(posedge clk); #1;
      end
      nl_if.nl_ack = 1'b0;
      if (ack_dly[g] >= 0) mpos[g] = nd;
      chk("ghost_moved", gmoved, (ack_dly[g] >= 0) ? (1 << g) : 0);
      chk("commit_req", nl_if.nl_req, 0);
      chk("commit_busy", busy, 1);
      chk("commit_pos", gpos[g*PW +: PW], mpos[g]);
      if (pellet_at == g + 1) begin pellet = 1'b1; m_pellet(); end
      if (tick_mid_at == g) begin tick = 1'b1; m_over = 1; end
      @(posedge clk); #1;
      pellet = 1'b0; tick = 1'b0;
    end
    chk("end_busy", busy, 0);
    chk("end_moved", gmoved, 0);
    chk("end_req", nl_if.nl_req, 0);
    chk("overrun", overrun, m_over);
    chk("mode", mode, m_mode());
    check_all_pos("end_pos");
  endtask

  task automatic random_rounds(input int n);
    for (int r = 0; r < n; r++) begin
      set_defaults();
      for (int i = 0; i < NUM_GHOSTS; i++) ack_dly[i] = int'($urandom_range(0, 3));
      gtgt = (NUM_GHOSTS*PW)'({$urandom(), $urandom()});
      run_round();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_defaults();
    m_restart();
    nl_if.nl_ack = 1'b0;
    nl_if.nl_next_pos = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", nl_if.nl_req, 0);
    chk("rst_curr", nl_if.nl_curr_pos, 0);
    chk("rst_tgt", nl_if.nl_target_pos, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_mode", mode, 0);
    chk("rst_moved", gmoved, 0);
    check_all_pos("rst_pos");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_round();
    random_rounds(5);
    gtgt[1*PW +: PW] = 10'd100;
    set_defaults();
    run_round();
    chk("mode_after_7", mode, 1);
    run_round();
    random_rounds(4);
    gtgt[1*PW +: PW] = 10'd100;

    pellet = 1'b1; m_pellet();
    @(posedge clk); #1;
    pellet = 1'b0;
    chk("mode_pellet", mode, 2);
    random_rounds(6);
    chk("mode_fright_done", mode, 1);
    random_rounds(14);
    chk("mode_chase_hold", mode, 1);
    random_rounds(1);
    chk("mode_scatter_again", mode, 0);

    set_defaults(); tick_mid_at = 1;
    run_round();
    set_defaults(); ack_dly[2] = 10; np_force[2] = 37;
    run_round();
    chk("pos2_37", gpos[2*PW +: PW], 37);
    set_defaults(); pellet_w_tick = 1;
    run_round();
    set_defaults(); pellet_at = 2;
    run_round();

    tick = 1'b1; m_tick();
    @(posedge clk); #1;
    tick = 1'b0; restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0; m_restart();
    chk("restart_req", nl_if.nl_req, 0);
    chk("restart_busy", busy, 0);
    chk("restart_overrun", overrun, 0);
    chk("restart_mode", mode, 0);
    check_all_pos("restart_pos");

    for (int r = 0; r < 6; r++) begin
      set_defaults();
      for (int i = 0; i < NUM_GHOSTS; i++) ack_dly[i] = int'($urandom_range(0, 4));
      pellet_at = int'($urandom_range(0, 4)) - 1;
      pellet_w_tick = ($urandom_range(0, 3) == 0);
      gtgt = (NUM_GHOSTS*PW)'({$urandom(), $urandom()});
      run_round();
    end

    tick = 1'b1; m_tick();
    @(posedge clk); #1;
    tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", nl_if.nl_req, 0);
    nl_if.nl_ack = 1'b1; nl_if.nl_next_pos = 10'd5;
    @(posedge clk); #1;
    rst_n = 1'b1; m_restart();
    @(posedge clk); #1;
    chk("idle_ack_moved", gmoved, 0);
    chk("idle_ack_busy", busy, 0);
    check_all_pos("idle_ack_pos");
    nl_if.nl_ack = 1'b0;

`ifdef GHOST_TIMEOUT_EN
    set_defaults(); ack_dly[3] = -1;
    run_round();
    chk("timeout_err", terr, 1);
`endif
    random_rounds(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
